// File: rtl/rot_voxel_buffer.sv
// ---------------------------------------------------------------------------
// rot_voxel_buffer
//
// Double-buffered voxel store for a rotating (persistence-of-vision) display.
// The scan converter sets or clears single voxels in the back bank with a
// read-modify-write of one radial row. The LED row driver reads whole rows
// from the front bank. On request the banks swap; with CLEAR_ON_SWAP set, the
// bank that has just become the back bank is wiped one row per cycle.
//
// Ports
//   clk_in, rst_in          clock, asynchronous active-low reset
//   new_data, wr_ready      voxel write handshake
//   theta, radius, y        voxel coordinates (slice, bit in row, row in slice)
//   wr_val                  1 = set voxel, 0 = clear voxel
//   data_ready              1-cycle pulse: accepted write committed
//   oor_err                 1-cycle pulse: accepted write dropped (out of range)
//   oor_count               saturating count of dropped writes
//   swap_req                bank swap request (pulse or level)
//   swap_done               1-cycle pulse: swap (and clear) finished
//   front_bank              index of the bank the read port uses
//   rd_en, addr_in          row read strobe and linear row address
//   rd_valid, row_out       registered read response, one cycle after rd_en
//
// Write handshake: a write transfers on a rising clock edge where both
// new_data and wr_ready are high. wr_ready depends only on internal state
// (never on new_data), so the producer may hold new_data and its
// coordinates stable until it sees the transfer.
// ---------------------------------------------------------------------------
module rot_voxel_buffer #(
    parameter int ROTATIONAL_RES = 32,
    parameter int HEIGHT         = 64,
    parameter int RADIAL_RES     = 64,
    parameter int CLEAR_ON_SWAP  = 1,
    localparam int N_ROWS        = ROTATIONAL_RES * HEIGHT,
    localparam int AW            = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  new_data,
    input  logic [7:0]            theta,
    input  logic [7:0]            radius,
    input  logic [7:0]            y,
    input  logic                  wr_val,
    output logic                  wr_ready,
    output logic                  data_ready,
    output logic                  oor_err,
    output logic [15:0]           oor_count,
    input  logic                  swap_req,
    output logic                  swap_done,
    output logic                  front_bank,
    input  logic                  rd_en,
    input  logic [AW-1:0]         addr_in,
    output logic                  rd_valid,
    output logic [RADIAL_RES-1:0] row_out
);

    localparam int            BW       = (RADIAL_RES > 1) ? $clog2(RADIAL_RES) : 1;
    localparam logic [AW-1:0] LAST_ROW = AW'(N_ROWS - 1);

    typedef enum logic [2:0] {
        ST_INIT_CLR = 3'd0,
        ST_IDLE     = 3'd1,
        ST_RMW_RD   = 3'd2,
        ST_RMW_WR   = 3'd3,
        ST_SWAP     = 3'd4,
        ST_SWAP_CLR = 3'd5
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t                state_q,        state_d;
    logic [AW-1:0]         clr_cnt_q,      clr_cnt_d;
    logic                  swap_pending_q, swap_pending_d;
    logic                  front_bank_q,   front_bank_d;
    logic [AW-1:0]         row_addr_q,     row_addr_d;
    logic [BW-1:0]         bit_idx_q,      bit_idx_d;
    logic                  wr_val_q,       wr_val_d;
    logic                  data_ready_q,   data_ready_d;
    logic                  oor_err_q,      oor_err_d;
    logic [15:0]           oor_count_q,    oor_count_d;
    logic                  swap_done_q,    swap_done_d;
    logic                  rd_valid_q;
    logic [RADIAL_RES-1:0] row_out_q;
    logic [RADIAL_RES-1:0] rmw_row_q;

    // Storage: one row-wide array per bank
    logic [RADIAL_RES-1:0] bank0_mem [N_ROWS];
    logic [RADIAL_RES-1:0] bank1_mem [N_ROWS];

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic                  handshake;
    logic                  coord_in_range;
    logic                  clr_last;
    logic [1:0]            back_sel;
    logic [1:0]            bank_we;
    logic [AW-1:0]         bank_waddr;
    logic [RADIAL_RES-1:0] bank_wdata;
    logic [RADIAL_RES-1:0] row_mod;
    logic                  rd_addr_ok;

    assign handshake      = new_data && wr_ready;
    assign coord_in_range = (int'(theta)  < ROTATIONAL_RES) &&
                            (int'(radius) < RADIAL_RES) &&
                            (int'(y)      < HEIGHT);
    assign clr_last       = (clr_cnt_q == LAST_ROW);
    // Write-enable mask of the bank that is NOT being displayed.
    assign back_sel       = front_bank_q ? 2'b01 : 2'b10;
    assign rd_addr_ok     = (int'(addr_in) < N_ROWS);

    // Row read back in RMW_RD with the single target bit replaced.
    always_comb begin
        row_mod            = rmw_row_q;
        row_mod[bit_idx_q] = wr_val_q;
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_INIT_CLR;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT_CLR: begin
                if (clr_last) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                // A handshake can only occur with no swap pending, so a
                // write that races a swap request completes before the swap.
                if (handshake) begin
                    if (coord_in_range) state_d = ST_RMW_RD;
                end else if (swap_pending_q) begin
                    state_d = ST_SWAP;
                end
            end
            ST_RMW_RD: state_d = ST_RMW_WR;
            ST_RMW_WR: state_d = ST_IDLE;
            ST_SWAP: begin
                state_d = (CLEAR_ON_SWAP != 0) ? ST_SWAP_CLR : ST_IDLE;
            end
            ST_SWAP_CLR: begin
                if (clr_last) state_d = ST_IDLE;
            end
            default: state_d = ST_INIT_CLR;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output logic (handshake ready and bank write port)
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ready   = 1'b0;
        bank_we    = 2'b00;
        bank_waddr = clr_cnt_q;
        bank_wdata = '0;
        case (state_q)
            ST_INIT_CLR: bank_we = 2'b11;      // wipe both banks together
            ST_IDLE:     wr_ready = !swap_pending_q;
            ST_RMW_WR: begin
                bank_we    = back_sel;
                bank_waddr = row_addr_q;
                bank_wdata = row_mod;
            end
            // front_bank_q has already toggled, so back_sel is the new back bank
            ST_SWAP_CLR: bank_we = back_sel;
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        clr_cnt_d      = '0;
        swap_pending_d = swap_pending_q;
        front_bank_d   = front_bank_q;
        row_addr_d     = row_addr_q;
        bit_idx_d      = bit_idx_q;
        wr_val_d       = wr_val_q;
        data_ready_d   = 1'b0;
        oor_err_d      = 1'b0;
        oor_count_d    = oor_count_q;
        swap_done_d    = 1'b0;

        // The counter idles at zero so each sweep starts at row 0.
        if ((state_q == ST_INIT_CLR) || (state_q == ST_SWAP_CLR)) begin
            clr_cnt_d = clr_last ? '0 : clr_cnt_q + 1'b1;
        end

        // A request is absorbed into one pending flag; the SWAP cycle
        // consumes it, but a request seen in that same cycle re-arms it.
        swap_pending_d = swap_req || (swap_pending_q && (state_q != ST_SWAP));

        if (state_q == ST_SWAP) begin
            front_bank_d = !front_bank_q;
        end

        if ((state_q == ST_IDLE) && handshake) begin
            if (coord_in_range) begin
                row_addr_d = AW'(int'(theta) * HEIGHT + int'(y));
                bit_idx_d  = radius[BW-1:0];
                wr_val_d   = wr_val;
            end else begin
                oor_err_d = 1'b1;
                if (oor_count_q != 16'hFFFF) begin
                    oor_count_d = oor_count_q + 16'd1;
                end
            end
        end

        data_ready_d = (state_q == ST_RMW_WR);
        swap_done_d  = ((state_q == ST_SWAP) && (CLEAR_ON_SWAP == 0)) ||
                       ((state_q == ST_SWAP_CLR) && clr_last);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            clr_cnt_q      <= '0;
            swap_pending_q <= 1'b0;
            front_bank_q   <= 1'b0;
            row_addr_q     <= '0;
            bit_idx_q      <= '0;
            wr_val_q       <= 1'b0;
            data_ready_q   <= 1'b0;
            oor_err_q      <= 1'b0;
            oor_count_q    <= '0;
            swap_done_q    <= 1'b0;
        end else begin
            clr_cnt_q      <= clr_cnt_d;
            swap_pending_q <= swap_pending_d;
            front_bank_q   <= front_bank_d;
            row_addr_q     <= row_addr_d;
            bit_idx_q      <= bit_idx_d;
            wr_val_q       <= wr_val_d;
            data_ready_q   <= data_ready_d;
            oor_err_q      <= oor_err_d;
            oor_count_q    <= oor_count_d;
            swap_done_q    <= swap_done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Bank storage: single write port shared by clear sweeps and RMW
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (bank_we[0]) bank0_mem[bank_waddr] <= bank_wdata;
        if (bank_we[1]) bank1_mem[bank_waddr] <= bank_wdata;
    end

    // RMW read port: fetch the target row of the back bank.
    always_ff @(posedge clk_in) begin
        if (state_q == ST_RMW_RD) begin
            rmw_row_q <= front_bank_q ? bank0_mem[row_addr_q] : bank1_mem[row_addr_q];
        end
    end

    // Display read port: independent of the FSM. It samples front_bank_q in
    // the strobe cycle, so a read during SWAP still sees the old front bank.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_valid_q <= 1'b0;
            row_out_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                if (!rd_addr_ok) begin
                    row_out_q <= '0;
                end else if (front_bank_q) begin
                    row_out_q <= bank1_mem[addr_in];
                end else begin
                    row_out_q <= bank0_mem[addr_in];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign data_ready = data_ready_q;
    assign oor_err    = oor_err_q;
    assign oor_count  = oor_count_q;
    assign swap_done  = swap_done_q;
    assign front_bank = front_bank_q;
    assign rd_valid   = rd_valid_q;
    assign row_out    = row_out_q;

endmodule

// File: tb/tb_rot_voxel_buffer.sv
// ---------------------------------------------------------------------------
// tb_rot_voxel_buffer
//
// Bench for rot_voxel_buffer with default parameters. Expected rows come from
// a behavioural model: two plain arrays of rows, a front-bank index and a
// dropped-write counter, updated from the voxel/swap rules directly.
// ---------------------------------------------------------------------------
module tb_rot_voxel_buffer;

    localparam int ROT = 32;
    localparam int HGT = 64;
    localparam int RAD = 64;
    localparam int N   = ROT * HGT;
    localparam int AW  = 11;

    localparam int OP_WR  = 0;
    localparam int OP_SWP = 1;
    localparam int OP_RD  = 2;

    // -----------------------------------------------------------------------
    // Clock / reset and DUT
    // -----------------------------------------------------------------------
    logic           clk_in = 1'b0;
    logic           rst_in = 1'b1;
    logic           new_data;
    logic [7:0]     theta;
    logic [7:0]     radius;
    logic [7:0]     y;
    logic           wr_val;
    logic           wr_ready;
    logic           data_ready;
    logic           oor_err;
    logic [15:0]    oor_count;
    logic           swap_req;
    logic           swap_done;
    logic           front_bank;
    logic           rd_en;
    logic [AW-1:0]  addr_in;
    logic           rd_valid;
    logic [RAD-1:0] row_out;

    always #5 clk_in = ~clk_in;

    rot_voxel_buffer #(
        .ROTATIONAL_RES(ROT),
        .HEIGHT        (HGT),
        .RADIAL_RES    (RAD),
        .CLEAR_ON_SWAP (1)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .new_data  (new_data),
        .theta     (theta),
        .radius    (radius),
        .y         (y),
        .wr_val    (wr_val),
        .wr_ready  (wr_ready),
        .data_ready(data_ready),
        .oor_err   (oor_err),
        .oor_count (oor_count),
        .swap_req  (swap_req),
        .swap_done (swap_done),
        .front_bank(front_bank),
        .rd_en     (rd_en),
        .addr_in   (addr_in),
        .rd_valid  (rd_valid),
        .row_out   (row_out)
    );

    // -----------------------------------------------------------------------
    // Scoreboard and reference model
    // -----------------------------------------------------------------------
    int             checks = 0;
    int             errors = 0;
    logic [RAD-1:0] exp_q[$];
    logic [RAD-1:0] mdl_bank [2][N];
    int             mdl_front;
    int             mdl_oor;

    function automatic void mdl_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < N; i++) mdl_bank[b][i] = '0;
        mdl_front = 0;
        mdl_oor   = 0;
    endfunction

    function automatic bit in_range(input int t, input int r, input int yy);
        return (t < ROT) && (r < RAD) && (yy < HGT);
    endfunction

    function automatic void mdl_write(input int t, input int r, input int yy, input bit v);
        if (!in_range(t, r, yy)) begin
            if (mdl_oor < 65535) mdl_oor++;
        end else begin
            mdl_bank[1 - mdl_front][t * HGT + yy][r] = v;
        end
    endfunction

    function automatic void mdl_swap();
        mdl_front = 1 - mdl_front;
        for (int i = 0; i < N; i++) mdl_bank[1 - mdl_front][i] = '0;
    endfunction

    function automatic logic [RAD-1:0] mdl_read(input int a);
        if (a >= N) return '0;
        return mdl_bank[mdl_front][a];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Driver tasks (drive and sample 1 time unit after the rising edge)
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_wr_ready"},   64'(wr_ready),   64'd0);
        chk({name, "_data_ready"}, 64'(data_ready), 64'd0);
        chk({name, "_oor_err"},    64'(oor_err),    64'd0);
        chk({name, "_oor_count"},  64'(oor_count),  64'd0);
        chk({name, "_swap_done"},  64'(swap_done),  64'd0);
        chk({name, "_front_bank"}, 64'(front_bank), 64'd0);
        chk({name, "_rd_valid"},   64'(rd_valid),   64'd0);
        chk({name, "_row_out"},    64'(row_out),    64'd0);
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (!wr_ready && n < 5000) begin
            tick();
            n++;
        end
        chk({name, "_init_cycles"}, 64'(n), 64'd2048);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!wr_ready && n < 5000) begin
            tick();
            n++;
        end
        chk({name, "_ready_wait"}, 64'(wr_ready), 64'd1);
    endtask

    task automatic wait_swap_done(input string name);
        int n;
        n = 0;
        while (!swap_done && n < 3000) begin
            tick();
            n++;
        end
        chk({name, "_swap_done"}, 64'(swap_done), 64'd1);
    endtask

    task automatic do_write(input int t, input int r, input int yy, input bit v);
        wait_ready("wr");
        new_data = 1'b1;
        theta    = 8'(t);
        radius   = 8'(r);
        y        = 8'(yy);
        wr_val   = v;
        tick();                              // handshake edge
        new_data = 1'b0;
        mdl_write(t, r, yy, v);
        if (!in_range(t, r, yy)) begin
            chk("wr_oor_err",    64'(oor_err),    64'd1);
            chk("wr_oor_dr",     64'(data_ready), 64'd0);
            chk("wr_oor_count",  64'(oor_count),  64'(mdl_oor));
            chk("wr_oor_ready",  64'(wr_ready),   64'd1);
            tick();
            chk("wr_oor_pulse",  64'(oor_err),    64'd0);
            chk("wr_oor_dr2",    64'(data_ready), 64'd0);
        end else begin
            chk("wr_dr_e0",      64'(data_ready), 64'd0);
            chk("wr_oor_e0",     64'(oor_err),    64'd0);
            chk("wr_busy",       64'(wr_ready),   64'd0);
            tick();
            chk("wr_dr_e1",      64'(data_ready), 64'd0);
            tick();
            chk("wr_dr_e2",      64'(data_ready), 64'd1);
            tick();
            chk("wr_dr_pulse",   64'(data_ready), 64'd0);
        end
    endtask

    task automatic do_swap(input string name);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        wait_swap_done(name);
        mdl_swap();
        chk({name, "_front"}, 64'(front_bank), 64'(mdl_front));
    endtask

    task automatic do_read(input int a, input string name);
        logic [RAD-1:0] e;
        rd_en   = 1'b1;
        addr_in = AW'(a);
        exp_q.push_back(mdl_read(a));
        tick();
        rd_en = 1'b0;
        e = exp_q.pop_front();
        chk({name, "_valid"}, 64'(rd_valid), 64'd1);
        chk({name, "_row"},   64'(row_out),  64'(e));
    endtask

    task automatic scan_front(input string name);
        logic [RAD-1:0] e;
        e     = '0;
        rd_en = 1'b1;
        for (int a = 0; a < N; a++) begin
            addr_in = AW'(a);
            exp_q.push_back(mdl_read(a));
            tick();
            e = exp_q.pop_front();
            chk({name, "_valid"}, 64'(rd_valid), 64'd1);
            chk({name, "_row"},   64'(row_out),  64'(e));
        end
        rd_en = 1'b0;
        tick();
        chk({name, "_idle_valid"}, 64'(rd_valid), 64'd0);
        chk({name, "_hold_row"},   64'(row_out),  64'(e));
    endtask

    // -----------------------------------------------------------------------
    // Directed vector table
    // -----------------------------------------------------------------------
    typedef struct {
        int             op;
        int             t;
        int             r;
        int             yy;
        int             v;
        int             addr;
        logic [63:0]    exp_row;
        int             exp_cnt;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    // -----------------------------------------------------------------------
    // Main sequence
    // -----------------------------------------------------------------------
    initial begin
        logic [RAD-1:0] exp_old;
        logic [RAD-1:0] exp_new;
        int             old_front;
        int             dr_cyc;
        int             sd_cyc;
        int             toggles;
        logic           prev_fb;
        int             t;
        int             r;
        int             yy;
        int             a;
        int             sel;

        vecs[0]  = '{OP_WR,  3, 10,  5, 1,    0, 64'h0,                 0};
        vecs[1]  = '{OP_SWP, 0,  0,  0, 0,    0, 64'h0,                 0};
        vecs[2]  = '{OP_RD,  0,  0,  0, 0,  197, 64'h400,               0};
        vecs[3]  = '{OP_WR,  0, 64,  0, 1,    0, 64'h0,                 1};
        vecs[4]  = '{OP_WR, 32,  0,  0, 1,    0, 64'h0,                 2};
        vecs[5]  = '{OP_WR,  0,  0, 64, 1,    0, 64'h0,                 3};
        vecs[6]  = '{OP_RD,  0,  0,  0, 0,  197, 64'h400,               3};
        vecs[7]  = '{OP_WR,  0,  0,  0, 1,    0, 64'h0,                 3};
        vecs[8]  = '{OP_WR,  0, 63,  0, 1,    0, 64'h0,                 3};
        vecs[9]  = '{OP_WR,  0,  0,  0, 0,    0, 64'h0,                 3};
        vecs[10] = '{OP_SWP, 0,  0,  0, 0,    0, 64'h0,                 3};
        vecs[11] = '{OP_RD,  0,  0,  0, 0,    0, 64'h8000_0000_0000_0000, 3};
        vecs[12] = '{OP_RD,  0,  0,  0, 0,  197, 64'h0,                 3};
        vecs[13] = '{OP_SWP, 0,  0,  0, 0,    0, 64'h0,                 3};
        vecs[14] = '{OP_RD,  0,  0,  0, 0,  197, 64'h0,                 3};
        vecs[15] = '{OP_SWP, 0,  0,  0, 0,    0, 64'h0,                 3};
        vecs[16] = '{OP_RD,  0,  0,  0, 0,    0, 64'h0,                 3};
        vecs[17] = '{OP_RD,  0,  0,  0, 0, 2047, 64'h0,                 3};

        new_data = 1'b0;
        theta    = '0;
        radius   = '0;
        y        = '0;
        wr_val   = 1'b0;
        swap_req = 1'b0;
        rd_en    = 1'b0;
        addr_in  = '0;

        // Reset and initial clear
        #2 rst_in = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst_in = 1'b1;
        wait_init("init");
        mdl_reset();
        scan_front("scan_a");
        do_swap("scan_swap");
        scan_front("scan_b");

        // Table-driven directed vectors
        for (int i = 0; i < NV; i++) begin
            case (vecs[i].op)
                OP_WR: begin
                    do_write(vecs[i].t, vecs[i].r, vecs[i].yy, 1'(vecs[i].v));
                    chk($sformatf("vec%0d_cnt", i), 64'(oor_count), 64'(vecs[i].exp_cnt));
                end
                OP_SWP: do_swap($sformatf("vec%0d", i));
                default: begin
                    do_read(vecs[i].addr, $sformatf("vec%0d", i));
                    chk($sformatf("vec%0d_tbl_row", i), 64'(row_out), vecs[i].exp_row);
                end
            endcase
        end

        // Read issued in the SWAP cycle returns the pre-toggle front bank
        do_write(0, 1, 5, 1'b1);
        do_swap("swc_setup");
        do_write(0, 2, 5, 1'b1);
        exp_old   = mdl_read(5);
        old_front = mdl_front;
        rd_en     = 1'b1;
        addr_in   = AW'(5);
        swap_req  = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("swc_rd0", 64'(row_out),    64'(exp_old));
        chk("swc_fb0", 64'(front_bank), 64'(old_front));
        tick();
        chk("swc_rd1", 64'(row_out),    64'(exp_old));
        chk("swc_fb1", 64'(front_bank), 64'(old_front));
        tick();
        mdl_swap();
        exp_new = mdl_read(5);
        chk("swc_rd2", 64'(row_out),    64'(exp_old));
        chk("swc_fb2", 64'(front_bank), 64'(mdl_front));
        tick();
        chk("swc_rd3", 64'(row_out),    64'(exp_new));
        rd_en = 1'b0;
        wait_swap_done("swc");

        // Swap request in the same cycle as a write handshake
        wait_ready("simul");
        prev_fb  = front_bank;
        toggles  = 0;
        dr_cyc   = -1;
        sd_cyc   = -1;
        new_data = 1'b1;
        theta    = 8'd1;
        radius   = 8'd7;
        y        = 8'd2;
        wr_val   = 1'b1;
        swap_req = 1'b1;
        tick();
        new_data = 1'b0;
        swap_req = 1'b0;
        mdl_write(1, 7, 2, 1'b1);
        for (int c = 0; c < 3000 && sd_cyc < 0; c++) begin
            if (data_ready && dr_cyc < 0) dr_cyc = c;
            if (swap_done) sd_cyc = c;
            if (front_bank !== prev_fb) toggles++;
            prev_fb = front_bank;
            if (sd_cyc < 0) tick();
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            if (front_bank !== prev_fb) toggles++;
            prev_fb = front_bank;
        end
        mdl_swap();
        chk("simul_swap_seen", 64'(sd_cyc >= 0), 64'd1);
        chk("simul_dr_latency", 64'(dr_cyc), 64'd2);
        chk("simul_order", 64'(dr_cyc >= 0 && dr_cyc < sd_cyc), 64'd1);
        chk("simul_toggles", 64'(toggles), 64'd1);
        chk("simul_front", 64'(front_bank), 64'(mdl_front));
        do_read(1 * HGT + 2, "simul_rd");

        // Reset asserted in the middle of a read-modify-write
        do_read(1 * HGT + 2, "mid_pre");
        wait_ready("mid");
        new_data = 1'b1;
        theta    = 8'd2;
        radius   = 8'd4;
        y        = 8'd1;
        wr_val   = 1'b1;
        tick();
        new_data = 1'b0;
        #2 rst_in = 1'b0;
        #1;
        chk_reset_outputs("mid_rmw");
        tick();
        tick();
        rst_in = 1'b1;
        wait_init("reinit");
        mdl_reset();
        do_read(2 * HGT + 1, "reinit_a_rmw_row");
        do_read(1 * HGT + 2, "reinit_a_old_row");
        do_swap("reinit_swap");
        do_read(2 * HGT + 1, "reinit_b_rmw_row");
        do_read(1 * HGT + 2, "reinit_b_old_row");

        // Randomized mix of writes, reads and swaps against the model
        for (int k = 0; k < 150; k++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 4) begin
                do_swap("rnd_swap");
            end else if (sel < 50) begin
                t  = int'($urandom_range(0, 3));
                r  = int'($urandom_range(0, RAD - 1));
                yy = int'($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       t  = int'($urandom_range(ROT, 255));
                        1:       r  = int'($urandom_range(RAD, 255));
                        default: yy = int'($urandom_range(HGT, 255));
                    endcase
                end
                do_write(t, r, yy, 1'($urandom_range(0, 1)));
            end else begin
                if ($urandom_range(0, 7) == 0) begin
                    a = int'($urandom_range(0, N - 1));
                end else begin
                    a = int'($urandom_range(0, 3)) * HGT + int'($urandom_range(0, 3));
                end
                do_read(a, "rnd_rd");
            end
        end
        chk("rnd_oor_count", 64'(oor_count), 64'(mdl_oor));
        do_swap("rnd_final_swap");
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) do_read(i * HGT + j, "rnd_final_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "time limit");
    end

endmodule
